// File: rtl/a1_y_mult_iter.sv
// a1_y_mult_iter: iterative unsigned a1*y multiplier, one DIGIT_W-bit slice of y per clock.
// The product drops its top 9 bits on output; o_ovf flags when any of them were set.
module a1_y_mult_iter #(
   parameter int MAN_WIDTH = 52,
   parameter int RNE       = 2,
   parameter int RNE1      = 49,
   parameter int DIGIT_W   = 17,
   localparam int A_W       = MAN_WIDTH + 1 + RNE,
   localparam int P_W       = A_W + RNE1,
   localparam int O_W       = P_W - 9,
   localparam int NUM_STEPS = (RNE1 + DIGIT_W - 1) / DIGIT_W
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic [A_W-1:0]  i_a1,
   input  logic [RNE1-1:0] i_y,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [O_W-1:0]  o_a1_y_rne1_dlt9zeros,
   output logic           o_ovf
);
   localparam int Y_W   = NUM_STEPS * DIGIT_W;
   localparam int CNT_W = NUM_STEPS > 1 ? $clog2(NUM_STEPS) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [A_W-1:0]   a1_r;
   logic [Y_W-1:0]   y_r, y_sh;
   logic [P_W-1:0]   acc, acc_n, part;
   logic [DIGIT_W-1:0] digit;
   logic             last;

   // y is zero-extended to whole digits, so the top partial digit reads zeros above RNE1-1
   always_comb begin
      y_sh    = y_r >> (DIGIT_W * cnt);
      digit   = y_sh[DIGIT_W-1:0];
      part    = ({{(P_W-A_W){1'b0}}, a1_r} * {{(P_W-DIGIT_W){1'b0}}, digit}) << (DIGIT_W * cnt);
      acc_n   = acc + part;
      last    = cnt == CNT_W'(NUM_STEPS - 1);
      o_ready = state == IDLE;
      o_valid = state == DONE;
      state_n = state == IDLE ? (i_valid ? MUL : IDLE) :
                state == MUL  ? (last ? DONE : MUL) :
                                (i_ready ? IDLE : DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state                 <= IDLE;
         cnt                   <= '0;
         a1_r                  <= '0;
         y_r                   <= '0;
         acc                   <= '0;
         o_a1_y_rne1_dlt9zeros <= '0;
         o_ovf                 <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && i_valid) begin
            a1_r <= i_a1;
            y_r  <= Y_W'(i_y);
            acc  <= '0;
            cnt  <= '0;
         end
         if (state == MUL) begin
            acc <= acc_n;
            cnt <= last ? cnt : cnt + 1'b1;
            // outputs load once per product so they hold between results
            if (last) begin
               o_a1_y_rne1_dlt9zeros <= acc_n[O_W-1:0];
               o_ovf                 <= |acc_n[P_W-1:O_W];
            end
         end
      end
   end
endmodule

// File: tb/tb_a1_y_mult_iter.sv
// tb_a1_y_mult_iter: directed + randomized checks of a1_y_mult_iter against a plain a1*y model.
module tb_a1_y_mult_iter;
   localparam int A_W       = 55;
   localparam int RNE1      = 49;
   localparam int P_W       = A_W + RNE1;
   localparam int O_W       = P_W - 9;
   localparam int NUM_STEPS = 3;

   logic           i_clk = 1'b0;
   logic           i_rst_n;
   logic           i_valid;
   logic           o_ready;
   logic [A_W-1:0]  i_a1;
   logic [RNE1-1:0] i_y;
   logic           o_valid;
   logic           i_ready;
   logic [O_W-1:0]  o_out;
   logic           o_ovf;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_acc = 0;
   logic [63:0] rr;

   a1_y_mult_iter dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_a1(i_a1),
      .i_y(i_y),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_a1_y_rne1_dlt9zeros(o_out),
      .o_ovf(o_ovf)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic scramble();
      rr   = {$urandom(), $urandom()};
      i_a1 = rr[A_W-1:0];
      rr   = {$urandom(), $urandom()};
      i_y  = rr[RNE1-1:0];
   endtask

   task automatic do_op(input logic [A_W-1:0] a, input logic [RNE1-1:0] y, input int stall,
                        input bit hold_valid, input bit chk_gap);
      logic [P_W-1:0] exp;
      logic [O_W-1:0] h_out;
      logic           h_ovf;
      int             lat;
      int             w;
      exp = {{(P_W-A_W){1'b0}}, a} * {{(P_W-RNE1){1'b0}}, y};
      w = 0;
      while (!o_ready && w < 20) begin
         @(posedge i_clk); #1;
         w++;
      end
      chk("ready_idle", 128'(o_ready), 128'(1));
      i_valid = 1'b1;
      i_a1    = a;
      i_y     = y;
      i_ready = stall == 0;
      @(posedge i_clk); #1;
      if (chk_gap) chk("accept_gap", 128'(cyc - last_acc), 128'(NUM_STEPS + 2));
      last_acc = cyc;
      chk("busy", 128'(o_ready), 128'(0));
      lat = 0;
      while (!o_valid && lat < 10) begin
         i_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
         scramble();
         @(posedge i_clk); #1;
         lat++;
      end
      chk("latency", 128'(lat), 128'(NUM_STEPS));
      chk("product", 128'(o_out), 128'(exp[O_W-1:0]));
      chk("ovf", 128'(o_ovf), 128'(|exp[P_W-1:O_W]));
      h_out = o_out;
      h_ovf = o_ovf;
      for (int i = 0; i < stall; i++) begin
         i_valid = ~i_valid;
         scramble();
         @(posedge i_clk); #1;
         chk("stall_valid", 128'(o_valid), 128'(1));
         chk("stall_busy", 128'(o_ready), 128'(0));
         chk("stall_out", 128'(o_out), 128'(h_out));
         chk("stall_ovf", 128'(o_ovf), 128'(h_ovf));
      end
      i_ready = 1'b1;
      i_valid = hold_valid;
      @(posedge i_clk); #1;
      chk("released", 128'(o_valid), 128'(0));
      chk("idle_again", 128'(o_ready), 128'(1));
      chk("hold_out", 128'(o_out), 128'(h_out));
   endtask

   initial begin
      logic [A_W-1:0]  a;
      logic [RNE1-1:0] y;
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_a1    = '0;
      i_y     = '0;
      #12;
      chk("rst_ready", 128'(o_ready), 128'(1));
      chk("rst_valid", 128'(o_valid), 128'(0));
      chk("rst_out", 128'(o_out), 128'(0));
      chk("rst_ovf", 128'(o_ovf), 128'(0));
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;

      a = '0; a[54] = 1'b1;
      do_op(a, 49'd1, 0, 0, 0);
      do_op({A_W{1'b1}}, {RNE1{1'b1}}, 0, 0, 0);
      y = '0; y[48] = 1'b1;
      do_op(55'd3, y, 0, 0, 0);
      scramble();
      do_op(i_a1, i_y, 5, 0, 0);

      // abort in the middle of a multiply
      scramble();
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b0;
      #1;
      chk("abort_ready", 128'(o_ready), 128'(1));
      chk("abort_valid", 128'(o_valid), 128'(0));
      chk("abort_out", 128'(o_out), 128'(0));
      chk("abort_ovf", 128'(o_ovf), 128'(0));
      repeat (2) begin
         @(posedge i_clk); #1;
         chk("abort_hold_ready", 128'(o_ready), 128'(1));
      end
      i_rst_n = 1'b1;
      repeat (5) begin
         @(posedge i_clk); #1;
         chk("abort_no_valid", 128'(o_valid), 128'(0));
      end
      do_op(55'd5, 49'd7, 0, 0, 0);
      chk("five_by_seven", 128'(o_out), 128'(35));

      for (int i = 0; i < 4; i++) begin
         scramble();
         do_op(i_a1 >> $urandom_range(0, 30), i_y >> $urandom_range(0, 30), $urandom_range(1, 3), 0, 0);
      end

      for (int i = 0; i < 10; i++) begin
         scramble();
         do_op(i_a1 >> $urandom_range(0, 20), i_y, 0, 1, i > 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/a1_y_mult_iter.md
A1_Y_MULT_ITER -- requirements
Module: ipsxe_floating_point_a1_y_mult_iter_v1_0

Interface
REQ-001 Parameter MAN_WIDTH, default 52, mantissa width excluding hidden bit.
REQ-002 Parameter RNE, default 2, extra guard bits carried on a1.
REQ-003 Parameter RNE1, default 49, width of y, i.e. the bits later consumed by the rounding stage.
REQ-004 Parameter DIGIT_W, default 17, y-digit width per multiply step.
REQ-005 Derived widths:
- A_W = MAN_WIDTH+1+RNE (default 55).
- P_W = A_W+RNE1 (default 104).
- O_W = P_W-9 (default 95).
- NUM_STEPS = ceil(RNE1/DIGIT_W) (default 3).
REQ-006 Reset is asynchronous and active-low; the block has one clock. Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  async active-low reset.
REQ-007 i_valid  input  1  operand pair valid.
REQ-008 o_ready  output  1  block can accept operands.
REQ-009 i_a1  input  A_W  unsigned a1.
REQ-010 i_y  input  RNE1  unsigned y.
REQ-011 o_valid  output  1  product valid.
REQ-012 i_ready  input  1  downstream (RNE stage) accepts product.
REQ-013 o_a1_y_rne1_dlt9zeros  output  O_W  product a1*y with top 9 bits deleted.
REQ-014 o_ovf  output  1  deleted top 9 bits were not all zero.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DONE; o_ready SHALL be 1 only in IDLE.
REQ-016 Accept in IDLE on i_valid&&o_ready:
- register i_a1 and i_y;
- clear the P_W-bit accumulator;
- set step counter to 0;
- go to MUL.
REQ-017 In MUL, each clock SHALL add a1 * y[k*DIGIT_W +: DIGIT_W] shifted left by k*DIGIT_W to the accumulator, where k is the counter; y bits above RNE1-1 read as zero.
REQ-018 After the step with k = NUM_STEPS-1, the FSM SHALL go to DONE; the counter SHALL never exceed NUM_STEPS-1.
REQ-019 Latency: o_valid SHALL rise exactly NUM_STEPS clock edges after the accepting edge (default 3).
REQ-020 In DONE:
- o_valid = 1;
- o_a1_y_rne1_dlt9zeros = accumulator[O_W-1:0];
- o_ovf = |accumulator[P_W-1:O_W].
REQ-021 While o_valid && !i_ready, outputs SHALL hold stable.
REQ-022 On o_valid && i_ready the FSM SHALL return to IDLE.
REQ-023 o_valid SHALL fall on the edge after handshake; the next accept is possible one cycle later; no back-to-back pass-through.
REQ-024 i_valid, i_a1 and i_y SHALL be ignored outside IDLE; operand registers SHALL not change in MUL or DONE.
REQ-025 Arithmetic SHALL be unsigned, full precision, with no truncation inside the accumulator; truncation happens only at output.
REQ-026 Outside DONE, o_a1_y_rne1_dlt9zeros and o_ovf SHALL keep their last values; downstream qualifies them with o_valid only.
REQ-027 Steady-state throughput: one product per NUM_STEPS+2 cycles with i_ready tied high.

Reset
REQ-028 While i_rst_n=0, the block SHALL immediately reset:
- state IDLE, counter 0;
- accumulator and operand registers 0;
- o_valid = 0, o_ovf = 0, o_a1_y_rne1_dlt9zeros = 0;
- o_ready = 1 (IDLE).
REQ-029 Reset asserted during MUL or DONE SHALL abort the operation; the in-flight product SHALL be discarded, never presented.
REQ-030 After reset release, the first accept is possible on the first rising edge with i_valid=1.

Verification
REQ-031 i_a1=2^54, i_y=1, i_ready=1 -> o_valid high 3 edges after accept; output = 2^54 (only bit 54 set); o_ovf=0.
REQ-032 i_a1=2^55-1, i_y=2^49-1 -> full product (2^55-1)(2^49-1); output = its low 95 bits; o_ovf=1.
REQ-033 i_a1=3, i_y=2^48 (top digit, partial 15-bit digit) -> output = 3*2^48; o_ovf=0.
REQ-034 i_ready=0 for 5 cycles in DONE, with i_valid toggling and random i_a1/i_y -> outputs constant; o_ready=0 throughout; product released on the first i_ready=1 cycle.
REQ-035 i_rst_n pulsed low in MUL step 1 -> o_valid never rises for that operand; o_ready=1 during reset; the next operand (i_a1=5, i_y=7) yields 35 with latency 3.
REQ-036 Continuous i_valid=1 and i_ready=1 over 10 random operands -> each output matches the reference model; accepts spaced 5 cycles apart.
